// File: rtl/aes_rx_checker.sv
// rtl/aes_rx_checker.sv - self-checking drain for the AES FIFO core's decrypt side
// Optional feature macro: AES_CHK_STOP_ON_FAIL_EN (end the run at the first mismatch)
module aes_rx_checker #(
    parameter int DATA_W     = 64,
    parameter int EXP_DEPTH  = 16,
    parameter int CNT_W      = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exp_we,
    input  logic [DATA_W-1:0] exp_data,
    output logic              exp_full,
    output logic              exp_ovf,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_pkts,
    output logic              busy,
    output logic              done,
    output logic              re,
    input  logic [DATA_W-1:0] decrypt_data,
    output logic              match,
    output logic              mismatch,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    localparam int AW = $clog2(EXP_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(EXP_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);
`ifdef AES_CHK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;

    state_t state;

    logic [DATA_W-1:0] mem [EXP_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level;
    logic [AW:0]       next_level;
    logic              fifo_empty;
    logic              do_push;
    logic              do_pop;
    logic [DATA_W-1:0] head;

    logic [CNT_W-1:0]  remaining;
    logic [1:0]        wait_cnt;
    logic [DATA_W-1:0] captured;
    logic              hit;

    assign fifo_empty = (level == '0);
    assign head       = mem[rd_ptr];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_pop     = (state == S_CMP) && !fifo_empty;
    assign do_push    = exp_we && (!exp_full || do_pop);

    always_comb begin
        next_level = level;
        if (do_push && !do_pop) begin
            next_level = level + 1'b1;
        end else if (do_pop && !do_push) begin
            next_level = level - 1'b1;
        end
    end

    always_comb begin
        hit = 1'b0;
        if (!fifo_empty && (captured == head)) begin
            hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= exp_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            exp_full <= 1'b0;
            exp_ovf  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level    <= next_level;
            exp_full <= (next_level == DEPTH_L);
            if (exp_we && !do_push) begin
                exp_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            re        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b0;
            mismatch  <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            captured  <= '0;
        end else begin
            re       <= 1'b0;
            done     <= 1'b0;
            match    <= 1'b0;
            mismatch <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= num_pkts;
                        pass_cnt  <= '0;
                        fail_cnt  <= '0;
                        busy      <= 1'b1;
                        if (num_pkts == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_REQ;
                            re    <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    state    <= S_WAIT;
                    wait_cnt <= WAIT_INIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        captured <= decrypt_data;
                        state    <= S_CMP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_CMP: begin
                    if (hit) begin
                        match <= 1'b1;
                        if (pass_cnt != CNT_MAX) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end else begin
                        mismatch <= 1'b1;
                        if (fail_cnt != CNT_MAX) begin
                            fail_cnt <= fail_cnt + 1'b1;
                        end
                    end
                    // remaining is always >= 1 here, so 1 means this was the last word.
                    if ((STOP_ON_FAIL && !hit) || (remaining == CNT_W'(1))) begin
                        remaining <= '0;
                        state     <= S_DONE;
                        done      <= 1'b1;
                    end else begin
                        remaining <= remaining - 1'b1;
                        state     <= S_REQ;
                        re        <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_rx_checker.sv
// tb/tb_aes_rx_checker.sv - directed bench for aes_rx_checker with a loopback core model
// Expectations for the stop-on-fail case follow AES_CHK_STOP_ON_FAIL_EN.
module tb_aes_rx_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        exp_we;
    logic [63:0] exp_data;
    logic        exp_full;
    logic        exp_ovf;
    logic        start;
    logic [15:0] num_pkts;
    logic        busy;
    logic        done;
    logic        re;
    logic [63:0] decrypt_data = '0;
    logic        match;
    logic        mismatch;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;

    aes_rx_checker dut (
        .clk          (clk),
        .rst          (rst),
        .exp_we       (exp_we),
        .exp_data     (exp_data),
        .exp_full     (exp_full),
        .exp_ovf      (exp_ovf),
        .start        (start),
        .num_pkts     (num_pkts),
        .busy         (busy),
        .done         (done),
        .re           (re),
        .decrypt_data (decrypt_data),
        .match        (match),
        .mismatch     (mismatch),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core model: returns the stored plaintext RD_LATENCY=1 edge after re, optionally corrupting one word.
    logic [63:0] core_mem [256];
    logic [63:0] core_w;
    int          rd_idx     = 0;
    int          wr_core    = 0;
    int          corrupt_at = -1;

    always @(posedge clk) begin
        if (re) begin
            core_w = core_mem[rd_idx % 256];
            if (rd_idx == corrupt_at) core_w[0] = 1'b1;
            rd_idx = rd_idx + 1;
            decrypt_data <= core_w;
        end
    end

    int cyc       = 0;
    int last_re   = -1;
    int re_cnt    = 0;
    int bad_gap   = 0;
    int done_cnt  = 0;
    int match_cnt = 0;
    int mism_cnt  = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!busy) last_re = -1;
        if (re) begin
            re_cnt = re_cnt + 1;
            if (last_re >= 0 && (cyc - last_re) != 3) bad_gap = bad_gap + 1;
            last_re = cyc;
        end
        if (done)     done_cnt  = done_cnt + 1;
        if (match)    match_cnt = match_cnt + 1;
        if (mismatch) mism_cnt  = mism_cnt + 1;
    end

    task automatic push_both(input logic [63:0] w);
        core_mem[wr_core % 256] = w;
        wr_core++;
        exp_we   = 1'b1;
        exp_data = w;
        @(posedge clk);
        #1 exp_we = 1'b0;
    endtask

    task automatic push_core(input logic [63:0] w);
        core_mem[wr_core % 256] = w;
        wr_core++;
    endtask

    task automatic kick(input logic [15:0] n);
        num_pkts = n;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_re(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (re) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wr_core = rd_idx;
    endtask

    int re0, done0, match0, mism0, gap0;

    task automatic snap();
        re0    = re_cnt;
        done0  = done_cnt;
        match0 = match_cnt;
        mism0  = mism_cnt;
        gap0   = bad_gap;
    endtask

    initial begin
        rst      = 1'b1;
        exp_we   = 1'b0;
        exp_data = '0;
        start    = 1'b0;
        num_pkts = '0;
        for (int i = 0; i < 256; i++) core_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_full", 64'(exp_full), 64'd0);
        check("rst_ovf", 64'(exp_ovf), 64'd0);
        check("rst_re", 64'(re), 64'd0);

        // Reset asserted while re is high must clear outputs before the next edge.
        for (int i = 0; i < 3; i++) push_both(64'h1000 + 64'(i));
        kick(16'd3);
        wait_re("midrst_re_seen");
        #1 rst = 1'b1;
        #1;
        check("midrst_re", 64'(re), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_match", 64'(match), 64'd0);
        check("midrst_mismatch", 64'(mismatch), 64'd0);
        check("midrst_pass", 64'(pass_cnt), 64'd0);
        check("midrst_fail", 64'(fail_cnt), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        wr_core = rd_idx;
        @(negedge clk);
        check("midrst_full", 64'(exp_full), 64'd0);
        check("midrst_ovf", 64'(exp_ovf), 64'd0);

        // Loopback of 10 random words.
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) push_both({$urandom, $urandom});
        snap();
        kick(16'd10);
        wait_done("loop_done_seen");
        check("loop_pass", 64'(pass_cnt), 64'd10);
        check("loop_fail", 64'(fail_cnt), 64'd0);
        check("loop_re_pulses", 64'(re_cnt - re0), 64'd10);
        check("loop_re_spacing", 64'(bad_gap - gap0), 64'd0);
        check("loop_done_once", 64'(done_cnt - done0), 64'd1);
        check("loop_match_pulses", 64'(match_cnt - match0), 64'd10);

        // Second start during a busy run is ignored.
        for (int i = 0; i < 5; i++) push_both(64'hA5A5_0000_0000_0000 + 64'(i));
        snap();
        kick(16'd5);
        repeat (4) @(posedge clk);
        #1;
        kick(16'd2);
        wait_done("busy_done_seen");
        check("busy_pass", 64'(pass_cnt), 64'd5);
        check("busy_fail", 64'(fail_cnt), 64'd0);
        check("busy_re_pulses", 64'(re_cnt - re0), 64'd5);
        check("busy_done_once", 64'(done_cnt - done0), 64'd1);

        // Zero-length run: done follows start directly, counts cleared, no re.
        snap();
        kick(16'd0);
        @(negedge clk);
        check("zero_done", 64'(done), 64'd1);
        check("zero_pass_cleared", 64'(pass_cnt), 64'd0);
        @(negedge clk);
        check("zero_done_pulse", 64'(done), 64'd0);
        check("zero_idle", 64'(busy), 64'd0);
        #1;
        check("zero_no_re", 64'(re_cnt - re0), 64'd0);

        // Corrupt bit 0 of the 4th of 10 words.
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) push_both({$urandom, $urandom} & ~64'h1);
        corrupt_at = rd_idx + 3;
        snap();
        kick(16'd10);
        wait_done("corr_done_seen");
        corrupt_at = -1;
        check("corr_mismatch_pulses", 64'(mism_cnt - mism0), 64'd1);
        check("corr_fail", 64'(fail_cnt), 64'd1);
`ifdef AES_CHK_STOP_ON_FAIL_EN
        check("corr_pass", 64'(pass_cnt), 64'd3);
        check("corr_re_pulses", 64'(re_cnt - re0), 64'd4);
`else
        check("corr_pass", 64'(pass_cnt), 64'd9);
        check("corr_re_pulses", 64'(re_cnt - re0), 64'd10);
`endif
        reset_dut();

        // FIFO boundaries: 17 pushes into 16 slots, then 18 reads.
        for (int i = 0; i < 15; i++) push_both(64'hF1F0_0000_0000_0000 + 64'(i));
        @(negedge clk);
        check("fifo_full_at15", 64'(exp_full), 64'd0);
        push_both(64'hF1F0_0000_0000_000F);
        @(negedge clk);
        check("fifo_full_at16", 64'(exp_full), 64'd1);
        check("fifo_ovf_at16", 64'(exp_ovf), 64'd0);
        push_both(64'hDEAD_BEEF_0000_0011);
        @(negedge clk);
        check("fifo_ovf_at17", 64'(exp_ovf), 64'd1);
        check("fifo_full_at17", 64'(exp_full), 64'd1);
        push_core(64'hDEAD_BEEF_0000_0012);
        kick(16'd18);
        wait_done("fifo_done_seen");
        check("fifo_pass", 64'(pass_cnt), 64'd16);
        check("fifo_fail", 64'(fail_cnt), 64'd2);
        check("fifo_empty_after", 64'(exp_full), 64'd0);
        reset_dut();

        // Push coinciding with the CMP pop while full.
        for (int i = 0; i < 16; i++) push_both(64'h5150_0000_0000_0000 + 64'(i));
        kick(16'd1);
        wait_re("sim_re_seen");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        exp_we   = 1'b1;
        exp_data = 64'h5150_FFFF_0000_0010;
        push_core(64'h5150_FFFF_0000_0010);
        @(posedge clk);
        #1 exp_we = 1'b0;
        wait_done("sim_done_seen");
        check("sim_pass", 64'(pass_cnt), 64'd1);
        check("sim_full", 64'(exp_full), 64'd1);
        check("sim_ovf", 64'(exp_ovf), 64'd0);
        kick(16'd16);
        wait_done("sim_drain_done_seen");
        check("sim_drain_pass", 64'(pass_cnt), 64'd16);
        check("sim_drain_fail", 64'(fail_cnt), 64'd0);
        check("sim_drain_empty", 64'(exp_full), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
